// File: rtl/can_tx_arbiter.sv
// Round-robin arbiter sharing one CAN controller transmit path between NUM_REQ frame sources.
// One frame is outstanding at a time; its result (or a timeout code) goes back to the granted source only.
module can_tx_arbiter #(
   parameter int         NUM_REQ        = 4,
   parameter int         TIMEOUT_CYCLES = 50_000,
   parameter logic [2:0] TIMEOUT_CODE   = 3'b111
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [64*NUM_REQ-1:0]      req_tdata,
   input  logic [11*NUM_REQ-1:0]      req_tid,
   input  logic [8*NUM_REQ-1:0]       req_tkeep,
   input  logic [NUM_REQ-1:0]         req_tvalid,
   output logic [NUM_REQ-1:0]         req_tready,
   output logic [2:0]                 res_tdata,
   output logic [NUM_REQ-1:0]         res_tvalid,
   input  logic [NUM_REQ-1:0]         res_tready,
   output logic [63:0]                ctl_tdata,
   output logic [10:0]                ctl_tid,
   output logic [7:0]                 ctl_tkeep,
   output logic                       ctl_tvalid,
   input  logic                       ctl_tready,
   input  logic [2:0]                 ctl_res_tdata,
   input  logic                       ctl_res_tvalid,
   output logic                       ctl_res_tready,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant,
   output logic                       stale_drop
);
   localparam int          GW      = $clog2(NUM_REQ);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RES, RETURN} state_t;

   state_t               state_reg, state_next;
   logic [GW-1:0]        grant_reg, grant_next;
   logic [GW-1:0]        last_grant_reg, last_grant_next;
   logic [2:0]           code_reg, code_next;
   logic [31:0]          cnt_reg, cnt_next;
   logic                 busy_reg, stale_reg, stale_next, res_ready_reg;
   logic [NUM_REQ-1:0]   res_valid_reg, res_valid_next;
   logic                 res_hs, found;
   logic [GW-1:0]        pick, cand;
   int                   idx;

   logic [63:0] tdata_arr [NUM_REQ];
   logic [10:0] tid_arr   [NUM_REQ];
   logic [7:0]  tkeep_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign tdata_arr[gi] = req_tdata[64*gi +: 64];
      assign tid_arr[gi]   = req_tid[11*gi +: 11];
      assign tkeep_arr[gi] = req_tkeep[8*gi +: 8];
   end

   // First valid requester after last_grant, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = last_grant_reg;
      idx   = 0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_grant_reg) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = idx[GW-1:0];
         if (!found && req_tvalid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      code_next       = code_reg;
      cnt_next        = cnt_reg;
      stale_next      = 1'b0;
      res_valid_next  = '0;
      res_hs          = ctl_res_tvalid & res_ready_reg;
      case (state_reg)
         IDLE: begin
            stale_next = res_hs;
            if (found) begin
               grant_next = pick;
               state_next = SEND;
            end
         end
         SEND: begin
            stale_next = res_hs;
            if (!req_tvalid[grant_reg]) begin
               state_next = IDLE;
            end else if (ctl_tready) begin
               cnt_next   = '0;
               state_next = WAIT_RES;
            end
         end
         WAIT_RES: begin
            // A real result beats a timeout firing in the same cycle.
            if (res_hs) begin
               code_next  = ctl_res_tdata;
               state_next = RETURN;
            end else if (TIMEOUT_CYCLES != 0 && cnt_reg == TO_LAST) begin
               code_next  = TIMEOUT_CODE;
               state_next = RETURN;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         RETURN: begin
            if (res_tready[grant_reg]) begin
               last_grant_next = grant_reg;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (state_next == RETURN) res_valid_next[grant_next] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GW'(NUM_REQ - 1);
         code_reg       <= '0;
         cnt_reg        <= '0;
         busy_reg       <= 1'b0;
         stale_reg      <= 1'b0;
         res_ready_reg  <= 1'b0;
         res_valid_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         code_reg       <= code_next;
         cnt_reg        <= cnt_next;
         busy_reg       <= (state_next != IDLE);
         stale_reg      <= stale_next;
         res_ready_reg  <= (state_next != RETURN);
         res_valid_reg  <= res_valid_next;
      end
   end

   always_comb begin
      req_tready = '0;
      if (state_reg == SEND) req_tready[grant_reg] = ctl_tready;
   end

   assign ctl_tvalid     = (state_reg == SEND);
   assign ctl_tdata      = tdata_arr[grant_reg];
   assign ctl_tid        = tid_arr[grant_reg];
   assign ctl_tkeep      = tkeep_arr[grant_reg];
   assign ctl_res_tready = res_ready_reg;
   assign res_tvalid     = res_valid_reg;
   assign res_tdata      = code_reg;
   assign busy           = busy_reg;
   assign grant          = grant_reg;
   assign stale_drop     = stale_reg;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed and randomized bench for can_tx_arbiter; a transaction-level model predicts grant order,
// result code and result latency from the arbitration and timeout rules.
module tb_can_tx_arbiter;
   localparam int         N       = 4;
   localparam int         TO      = 16;
   localparam logic [2:0] TO_CODE = 3'b111;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [64*N-1:0]        req_tdata;
   logic [11*N-1:0]        req_tid;
   logic [8*N-1:0]         req_tkeep;
   logic [N-1:0]           req_tvalid, req_tready, res_tvalid, res_tready;
   logic [2:0]             res_tdata;
   logic [63:0]            ctl_tdata;
   logic [10:0]            ctl_tid;
   logic [7:0]             ctl_tkeep;
   logic                   ctl_tvalid, ctl_tready;
   logic [2:0]             ctl_res_tdata;
   logic                   ctl_res_tvalid, ctl_res_tready;
   logic                   busy, stale_drop;
   logic [$clog2(N)-1:0]   grant;

   int errors = 0;
   int checks = 0;
   int hs_count = 0;
   int lg = N - 1;
   logic [63:0] f_data [N];
   logic [10:0] f_tid  [N];
   logic [7:0]  f_keep [N];
   logic [N-1:0] vmask;
   logic [N-1:0] one = 1;

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_tdata[64*gi +: 64] = f_data[gi];
      assign req_tid[11*gi +: 11]   = f_tid[gi];
      assign req_tkeep[8*gi +: 8]   = f_keep[gi];
   end
   assign req_tvalid = vmask;

   can_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .TIMEOUT_CODE(TO_CODE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_tdata(req_tdata), .req_tid(req_tid), .req_tkeep(req_tkeep),
      .req_tvalid(req_tvalid), .req_tready(req_tready),
      .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
      .ctl_tdata(ctl_tdata), .ctl_tid(ctl_tid), .ctl_tkeep(ctl_tkeep),
      .ctl_tvalid(ctl_tvalid), .ctl_tready(ctl_tready),
      .ctl_res_tdata(ctl_res_tdata), .ctl_res_tvalid(ctl_res_tvalid),
      .ctl_res_tready(ctl_res_tready),
      .busy(busy), .grant(grant), .stale_drop(stale_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && ctl_tvalid && ctl_tready) hs_count++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int last);
      for (int i = 1; i <= N; i++) if (m[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   task automatic new_frame(input int k);
      f_data[k] = {$urandom, $urandom};
      f_tid[k]  = 11'($urandom);
      f_keep[k] = 8'($urandom);
   endtask

   // One full transaction from IDLE: bp = cycles of ctl backpressure, d = WAIT_RES cycles
   // before the controller answers (negative = never), rdly = cycles before res_tready.
   task automatic serve(input int bp, input int d, input logic [2:0] code, input int rdly,
                        input bit keep_valid, output int g);
      int exp_g, waited, hs0, exp_lat;
      logic [2:0] exp_code;
      logic [10:0] tid_seen;
      exp_g = rr_pick(vmask, lg);
      hs0   = hs_count;
      step();
      g = int'(grant);
      tid_seen = ctl_tid;
      check("grant", grant, exp_g);
      check("ctl_tvalid", ctl_tvalid, 1);
      check("busy_send", busy, 1);
      check("ctl_fields", {ctl_tid, ctl_tkeep, ctl_tdata}, {f_tid[exp_g], f_keep[exp_g], f_data[exp_g]});
      for (int c = 0; c < bp; c++) begin
         check("bp_req_tready", req_tready, 0);
         check("bp_fields", {ctl_tid, ctl_tkeep, ctl_tdata}, {f_tid[exp_g], f_keep[exp_g], f_data[exp_g]});
         step();
      end
      ctl_tready = 1'b1;
      #1;
      check("req_tready", req_tready, one << exp_g);
      step();
      ctl_tready = 1'b0;
      check("ctl_hs_count", hs_count - hs0, 1);
      check("wait_ctl_tvalid", ctl_tvalid, 0);
      check("wait_res_ready", ctl_res_tready, 1);
      if (keep_valid) new_frame(exp_g); else vmask[exp_g] = 1'b0;
      exp_code = (d >= 0 && d < TO) ? code : TO_CODE;
      exp_lat  = (d >= 0 && d < TO) ? d + 1 : TO;
      waited = 0;
      while (waited < TO + 4 && res_tvalid == '0) begin
         if (waited == d) begin
            ctl_res_tvalid = 1'b1;
            ctl_res_tdata  = code;
         end
         step();
         waited++;
         ctl_res_tvalid = 1'b0;
      end
      check("res_latency", waited, exp_lat);
      check("res_tvalid", res_tvalid, one << exp_g);
      check("res_tdata", res_tdata, exp_code);
      check("ret_ctl_res_tready", ctl_res_tready, 0);
      for (int c = 0; c < rdly; c++) begin
         step();
         check("res_hold", res_tvalid, one << exp_g);
      end
      res_tready = one << exp_g;
      step();
      res_tready = '0;
      check("idle_res_tvalid", res_tvalid, 0);
      check("idle_busy", busy, 0);
      lg = exp_g;
      $display("txn grant=%0d tid=%h bp=%0d delay=%0d code=%0d wait=%0d", g, tid_seen, bp, d, res_tdata, waited);
   endtask

   initial begin
      int g, k;
      vmask = '0;
      ctl_tready = 1'b0;
      ctl_res_tvalid = 1'b0;
      ctl_res_tdata = '0;
      res_tready = '0;
      for (int i = 0; i < N; i++) new_frame(i);

      // Reset values
      #12;
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_stale", stale_drop, 0);
      check("rst_res_tvalid", res_tvalid, 0);
      check("rst_res_tdata", res_tdata, 0);
      check("rst_ctl_tvalid", ctl_tvalid, 0);
      check("rst_req_tready", req_tready, 0);
      check("rst_ctl_res_tready", ctl_res_tready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Single frame from requester 2
      f_tid[2] = 11'h123;
      f_data[2] = 64'h0011223344556677;
      f_keep[2] = 8'hFF;
      vmask = 4'b0100;
      #1;
      check("pre_latency_ctl_tvalid", ctl_tvalid, 0);
      serve(0, 10, 3'b000, 0, 1'b0, g);

      // Backpressure for 20 cycles
      vmask = 4'b1000;
      serve(20, 3, 3'b101, 1, 1'b0, g);

      // Timeout, then a late result dropped in IDLE
      vmask = 4'b0001;
      serve(0, -1, 3'b000, 0, 1'b0, g);
      ctl_res_tvalid = 1'b1;
      ctl_res_tdata = 3'b010;
      step();
      ctl_res_tvalid = 1'b0;
      check("late_stale_drop", stale_drop, 1);
      check("late_res_tvalid", res_tvalid, 0);
      step();
      check("late_stale_clear", stale_drop, 0);
      check("late_res_tvalid2", res_tvalid, 0);
      check("late_busy", busy, 0);

      // Real result in the same cycle the timeout fires
      vmask = 4'b0010;
      serve(0, TO - 1, 3'b001, 0, 1'b0, g);

      // Requester withdraws valid in SEND: back to IDLE, priority unchanged
      vmask = 4'b0100;
      step();
      check("viol_grant", grant, rr_pick(4'b0100, lg));
      check("viol_busy", busy, 1);
      vmask = '0;
      step();
      check("viol_idle_busy", busy, 0);
      check("viol_ctl_tvalid", ctl_tvalid, 0);
      for (int i = 0; i < N; i++) new_frame(i);
      vmask = '1;
      serve(0, 0, 3'b011, 0, 1'b0, g);

      // Reset in WAIT_RES
      vmask = 4'b0010;
      step();
      ctl_tready = 1'b1;
      step();
      ctl_tready = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant", grant, 0);
      check("mid_rst_res_tvalid", res_tvalid, 0);
      check("mid_rst_ctl_res_tready", ctl_res_tready, 0);
      check("mid_rst_ctl_tvalid", ctl_tvalid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      lg = N - 1;
      for (int i = 0; i < N; i++) new_frame(i);
      vmask = '1;

      // Round-robin with all requesters continuously valid
      for (int i = 0; i < 5; i++) begin
         serve(0, 0, 3'($urandom), 0, 1'b1, g);
         check("rr_order", g, i % N);
      end

      // Randomized traffic
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!vmask[i] && $urandom_range(0, 1) == 1) begin
               new_frame(i);
               vmask[i] = 1'b1;
            end
         end
         if (vmask == '0) begin
            k = int'($urandom_range(0, N - 1));
            new_frame(k);
            vmask[k] = 1'b1;
         end
         serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 3'($urandom),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), g);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
